uart0_fifo_bridge: RTL and testbench

UART0_FIFO_BRIDGE -- requirements
Module: uart0_fifo_bridge

---
 rtl/uart0_fifo_bridge.sv | 190 +++++++++++++++++++
 tb/tb_uart0_fifo_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart0_fifo_bridge.sv
// uart0_fifo_bridge: CPU register window in front of a UART with TX/RX byte FIFOs.
// Ports: clk, reset (sync, active-high); bus_valid/bus_wr/bus_addr/bus_wdata in,
//   bus_rdata out (registered); tx_rdy in, tx_vld/tx_data out (launch pulse);
//   rx_valid/rx_data in; irq out (registered level).
// Build option: define UART_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO; otherwise
//   the RX path is a single holding register.

module uart0_fifo_bridge_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Explicit wrap so non-power-of-2 and single-entry depths also work.
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // push/pop arrive already qualified against full/empty by the caller.
    always_comb begin
        count_nxt = flush ? '0 : count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= inc(wptr);
            if (pop)  rptr <= inc(rptr);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && push) mem[wptr] <= wdata;
    end

    assign head = mem[rptr];
endmodule

module uart0_fifo_bridge #(
    parameter int WL       = 32,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bus_valid,
    input  logic          bus_wr,
    input  logic [1:0]    bus_addr,
    input  logic [WL-1:0] bus_wdata,
    output logic [WL-1:0] bus_rdata,
    input  logic          tx_rdy,
    output logic          tx_vld,
    output logic [7:0]    tx_data,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          irq
);
`ifdef UART_RX_FIFO_EN
    localparam int RXD = RX_DEPTH;
`else
    localparam int RXD = 1;
`endif
    localparam int TXCW = $clog2(TX_DEPTH + 1);
    localparam int RXCW = $clog2(RXD + 1);

    logic [TXCW-1:0] tx_cnt, tx_cnt_nxt;
    logic [RXCW-1:0] rx_cnt, rx_cnt_nxt;
    logic [7:0]      tx_head, rx_head;
    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic            tx_push, tx_pop, tx_drop, tx_flush;
    logic            rx_push, rx_pop, rx_drop, rx_flush;
    logic            wr_acc, rd_acc, sel_data, sel_ctrl, clr_wr;
    logic            tx_ovf, rx_ovf, tx_ovf_nxt, rx_ovf_nxt;
    logic [1:0]      ctrl, ctrl_nxt;
    logic            irq_nxt;
    logic [WL-1:0]   rdata_nxt;
    logic [31:0]     status;

    assign wr_acc   = bus_valid & bus_wr;
    assign rd_acc   = bus_valid & ~bus_wr;
    assign sel_data = (bus_addr == 2'd0);
    assign sel_ctrl = (bus_addr == 2'd2);
    assign clr_wr   = wr_acc & (bus_addr == 2'd3);

    assign tx_full  = (tx_cnt == TXCW'(TX_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == RXCW'(RXD));
    assign rx_empty = (rx_cnt == '0);

    assign tx_flush = clr_wr & bus_wdata[8];
    assign rx_flush = clr_wr & bus_wdata[9];

    // Full is judged on the start-of-cycle count, so a same-cycle launch
    // does not rescue a write that arrives while the FIFO is full.
    assign tx_push = wr_acc & sel_data & ~tx_full;
    assign tx_drop = wr_acc & sel_data & tx_full;
    assign tx_pop  = tx_rdy & ~tx_empty & ~tx_vld & ~tx_flush;

    assign rx_push = rx_valid & ~rx_full;
    assign rx_drop = rx_valid & rx_full;
    assign rx_pop  = rd_acc & sel_data & ~rx_empty;

    uart0_fifo_bridge_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (tx_flush),
        .push      (tx_push),
        .pop       (tx_pop),
        .wdata     (bus_wdata[7:0]),
        .head      (tx_head),
        .count     (tx_cnt),
        .count_nxt (tx_cnt_nxt)
    );

    uart0_fifo_bridge_fifo #(.DEPTH(RXD)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (rx_flush),
        .push      (rx_push),
        .pop       (rx_pop),
        .wdata     (rx_data),
        .head      (rx_head),
        .count     (rx_cnt),
        .count_nxt (rx_cnt_nxt)
    );

    assign status = {8'd0, 8'(rx_cnt), 8'(tx_cnt), 2'b00,
                     rx_ovf, tx_ovf, rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        tx_ovf_nxt = tx_drop | (tx_ovf & ~(clr_wr & bus_wdata[4]));
        rx_ovf_nxt = rx_drop | (rx_ovf & ~(clr_wr & bus_wdata[5]));
        ctrl_nxt   = (wr_acc & sel_ctrl) ? bus_wdata[1:0] : ctrl;
        // irq tracks the state as it will be after this edge.
        irq_nxt    = (ctrl_nxt[0] & (rx_cnt_nxt != '0))
                   | (ctrl_nxt[1] & (tx_cnt_nxt == '0));
    end

    always_comb begin
        rdata_nxt = '0;
        if (bus_wr) begin
            rdata_nxt = bus_wdata;
        end else begin
            case (bus_addr)
                2'd0:    rdata_nxt = rx_pop ? {1'b1, 23'd0, rx_head} : '0;
                2'd1:    rdata_nxt = status;
                2'd2:    rdata_nxt = {30'd0, ctrl};
                default: rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_vld    <= 1'b0;
            tx_data   <= '0;
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
            ctrl      <= '0;
            bus_rdata <= '0;
            irq       <= 1'b0;
        end else begin
            tx_vld <= tx_pop;
            if (tx_pop) tx_data <= tx_head;
            tx_ovf <= tx_ovf_nxt;
            rx_ovf <= rx_ovf_nxt;
            ctrl   <= ctrl_nxt;
            if (bus_valid) bus_rdata <= rdata_nxt;
            irq    <= irq_nxt;
        end
    end
endmodule

// File: tb/tb_uart0_fifo_bridge.sv
// tb_uart0_fifo_bridge: directed stimulus with a queue-based scoreboard.
// Bus reads and TX launches are checked by a monitor decoupled from stimulus.

module tb_uart0_fifo_bridge;
`ifdef UART_RX_FIFO_EN
    localparam int RXD = 16;
`else
    localparam int RXD = 1;
`endif

    typedef struct packed {
        logic [31:0] v;
        logic        chk;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_valid = 1'b0;
    logic        bus_wr = 1'b0;
    logic [1:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        tx_rdy = 1'b0;
    logic        tx_vld;
    logic [7:0]  tx_data;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    rd_exp_t    rdq[$];
    logic [7:0] txq[$];
    logic       rd_pend = 1'b0;
    logic       prev_vld = 1'b0;

    uart0_fifo_bridge #(.WL(32), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_valid (bus_valid),
        .bus_wr    (bus_wr),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .tx_rdy    (tx_rdy),
        .tx_vld    (tx_vld),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    always @(posedge clk) rd_pend <= bus_valid;

    always @(negedge clk) begin
        rd_exp_t e;
        if (rd_pend) begin
            if (rdq.size() == 0) begin
                check("rdq_underflow", 32'd1, 32'd0);
            end else begin
                e = rdq.pop_front();
                if (e.chk) check("bus_rdata", bus_rdata, e.v);
            end
        end
        if (tx_vld) begin
            check("tx_vld_adjacent", {31'd0, prev_vld}, 32'd0);
            if (txq.size() == 0)
                check("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
            else
                check("tx_data", {24'd0, tx_data}, {24'd0, txq.pop_front()});
        end
        prev_vld = tx_vld;
    end

    task automatic bus(input logic wr, input logic [1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
        bus_valid = 1'b1;
        bus_wr    = wr;
        bus_addr  = addr;
        bus_wdata = wdata;
        rdq.push_back('{v: exp, chk: 1'b1});
        @(posedge clk);
        #1;
        bus_valid = 1'b0;
        bus_wr    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] d);
        bus(1'b1, addr, d, d);
    endtask

    task automatic rd(input logic [1:0] addr, input logic [31:0] exp);
        bus(1'b0, addr, 32'd0, exp);
    endtask

    task automatic rx_inject(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check("reset_rdata", bus_rdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_tx_vld", {31'd0, tx_vld}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);
        reset = 1'b0;
        idle(1);
        rd(2'd1, 32'h0000_0006);

        // Three bytes with an idle transmitter.
        tx_rdy = 1'b1;
        txq.push_back(8'h41);
        txq.push_back(8'h42);
        txq.push_back(8'h43);
        wr(2'd0, 32'h41);
        wr(2'd0, 32'h42);
        wr(2'd0, 32'h43);
        idle(10);
        rd(2'd1, 32'h0000_0006);

        // Fill TX past its depth with the transmitter held off.
        tx_rdy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) txq.push_back(8'(8'h60 + i));
            wr(2'd0, 32'h60 + i);
        end
        rd(2'd1, 32'h0000_1015);
        wr(2'd3, 32'h10);
        rd(2'd1, 32'h0000_1005);
        tx_rdy = 1'b1;
        idle(40);
        rd(2'd1, 32'h0000_0006);

        // CTRL read-back and TX-empty interrupt.
        wr(2'd2, 32'hFFFF_FFFF);
        check("irq_tx_empty", {31'd0, irq}, 32'd1);
        rd(2'd2, 32'h0000_0003);
        wr(2'd2, 32'h0);
        check("irq_off", {31'd0, irq}, 32'd0);
        rd(2'd3, 32'h0);

        // Single RX byte, then empty read.
        rx_inject(8'h55);
        rd(2'd0, 32'h8000_0055);
        rd(2'd0, 32'h0000_0000);

        // RX interrupt follows FIFO occupancy.
        wr(2'd2, 32'h1);
        rx_inject(8'hA5);
        check("irq_rx_set", {31'd0, irq}, 32'd1);
        rd(2'd0, 32'h8000_00A5);
        check("irq_rx_clr", {31'd0, irq}, 32'd0);
        wr(2'd2, 32'h0);

        // Empty-FIFO read colliding with an incoming byte.
        rx_valid = 1'b1;
        rx_data  = 8'h7E;
        bus(1'b0, 2'd0, 32'd0, 32'd0);
        rx_valid = 1'b0;
        rd(2'd1, 32'h0001_0002 | ((RXD == 1) ? 32'h8 : 32'h0));
        rd(2'd0, 32'h8000_007E);

        // RX overflow keeps the oldest bytes.
        for (int i = 0; i <= RXD; i++) rx_inject(8'(8'h10 + i));
        rd(2'd1, (32'(RXD) << 16) | 32'h2A);
        rd(2'd0, 32'h8000_0010);
        wr(2'd3, 32'h220);
        rd(2'd1, 32'h0000_0006);

        // Reset with bytes queued and the transmitter ready.
        tx_rdy = 1'b0;
        for (int i = 0; i < 5; i++) wr(2'd0, 32'hC0 + i);
        reset  = 1'b1;
        tx_rdy = 1'b1;
        idle(1);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
        idle(1);
        reset = 1'b0;
        idle(10);
        rd(2'd1, 32'h0000_0006);

        idle(5);
        check("rdq_drained", rdq.size(), 32'd0);
        check("txq_drained", txq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
